// File: rtl/exec_unit_if.sv
// Request/result bundle for exec_unit: operation and operands in, registered result out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface exec_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_op;
    logic [RD_W-1:0] in_rd;
    logic [XLEN-1:0] in_rs1_v;
    logic [XLEN-1:0] in_rs2_v;
    logic [XLEN-1:0] in_imm;
    logic            in_src2_imm;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            out_reg_we;
    logic [RD_W-1:0] out_rd;
    logic            out_mem_we;
    logic            out_mem_re;
    logic [XLEN-1:0] out_mem_addr;
    logic            out_jump;
    logic [XLEN-1:0] out_jump_dest;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, in_op, in_rd, in_rs1_v, in_rs2_v, in_imm, in_src2_imm, out_ready,
        input  in_ready, out_valid, out_data, out_reg_we, out_rd, out_mem_we, out_mem_re,
               out_mem_addr, out_jump, out_jump_dest, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_op, in_rd, in_rs1_v, in_rs2_v, in_imm, in_src2_imm, out_ready,
        output in_ready, out_valid, out_data, out_reg_we, out_rd, out_mem_we, out_mem_re,
               out_mem_addr, out_jump, out_jump_dest, out_illegal
    );
endinterface

// File: rtl/exec_unit.sv
// Integer execute stage: single-cycle ALU/branch/memory ops with a registered result slot.
// Define EXEC_UNIT_MDU_EN to add MUL and a 1-bit-per-cycle restoring divider (ops 22-26).
module exec_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    exec_unit_if.slave   io,
    output logic         dbg_busy
);
    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] a, b, sum_ri, pc_imm, pc4;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] r_data, r_addr, r_dest;
    logic            r_we, r_mem_we, r_mem_re, r_jump, r_ill, r_div;
    logic            idle, accept;

    assign a      = io.in_rs1_v;
    assign b      = io.in_src2_imm ? io.in_imm : io.in_rs2_v;
    assign shamt  = b[SH_W-1:0];
    assign sum_ri = io.in_rs1_v + io.in_imm;
    assign pc_imm = io.in_pc + io.in_imm;
    assign pc4    = io.in_pc + XLEN'(4);

    assign io.in_ready = idle && (!io.out_valid || io.out_ready);
    assign accept      = io.in_valid && io.in_ready && !flush;
    assign dbg_busy    = !idle;

    always_comb begin
        r_data   = '0;
        r_addr   = '0;
        r_dest   = '0;
        r_we     = 1'b0;
        r_mem_we = 1'b0;
        r_mem_re = 1'b0;
        r_jump   = 1'b0;
        r_ill    = 1'b0;
        r_div    = 1'b0;
        case (io.in_op)
            5'd0:  begin r_data = a + b;                                   r_we = 1'b1; end
            5'd1:  begin r_data = a - b;                                   r_we = 1'b1; end
            5'd2:  begin r_data = a & b;                                   r_we = 1'b1; end
            5'd3:  begin r_data = a | b;                                   r_we = 1'b1; end
            5'd4:  begin r_data = a ^ b;                                   r_we = 1'b1; end
            5'd5:  begin r_data = a << shamt;                              r_we = 1'b1; end
            5'd6:  begin r_data = a >> shamt;                              r_we = 1'b1; end
            5'd7:  begin r_data = $unsigned($signed(a) >>> shamt);         r_we = 1'b1; end
            5'd8:  begin r_data = XLEN'($signed(a) < $signed(b));          r_we = 1'b1; end
            5'd9:  begin r_data = XLEN'(a < b);                            r_we = 1'b1; end
            5'd10: begin r_data = io.in_imm;                               r_we = 1'b1; end
            5'd11: begin r_data = pc_imm;                                  r_we = 1'b1; end
            5'd12: begin r_data = pc4; r_jump = 1'b1; r_dest = pc_imm;     r_we = 1'b1; end
            5'd13: begin
                r_data = pc4; r_jump = 1'b1; r_we = 1'b1;
                r_dest = {sum_ri[XLEN-1:1], 1'b0};
            end
            // Branches compare rs1 against rs2 regardless of src2_imm; imm is the offset.
            5'd14: begin r_dest = pc_imm; r_jump = (a == io.in_rs2_v);                  end
            5'd15: begin r_dest = pc_imm; r_jump = (a != io.in_rs2_v);                  end
            5'd16: begin r_dest = pc_imm; r_jump = ($signed(a) <  $signed(io.in_rs2_v)); end
            5'd17: begin r_dest = pc_imm; r_jump = ($signed(a) >= $signed(io.in_rs2_v)); end
            5'd18: begin r_dest = pc_imm; r_jump = (a <  io.in_rs2_v);                  end
            5'd19: begin r_dest = pc_imm; r_jump = (a >= io.in_rs2_v);                  end
            5'd20: begin r_addr = sum_ri; r_mem_re = 1'b1; r_we = 1'b1;                 end
            5'd21: begin r_addr = sum_ri; r_mem_we = 1'b1; r_data = io.in_rs2_v;        end
`ifdef EXEC_UNIT_MDU_EN
            5'd22: begin r_data = a * io.in_rs2_v;                         r_we = 1'b1; end
            5'd23, 5'd24, 5'd25, 5'd26: r_div = 1'b1;
`endif
            default: r_ill = 1'b1;
        endcase
        if (io.in_rd == '0) r_we = 1'b0;
    end

`ifdef EXEC_UNIT_MDU_EN
    localparam int CNT_W = $clog2(XLEN) + 1;
    typedef enum logic {IDLE = 1'b0, DIV_BUSY = 1'b1} state_t;

    state_t          state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo, rem, den, q_res, r_res;
    logic [XLEN:0]   shifted, diff;
    logic            fits, neg_q, neg_r, div0, want_rem, div_done;
    logic            is_signed, rs1_neg, rs2_neg;
    logic [RD_W-1:0] div_rd;

    assign is_signed = (io.in_op == 5'd23) || (io.in_op == 5'd25);
    assign rs1_neg   = is_signed && a[XLEN-1];
    assign rs2_neg   = is_signed && io.in_rs2_v[XLEN-1];
    assign idle      = (state == IDLE);
    assign div_done  = (state == DIV_BUSY) && (cnt == CNT_W'(XLEN));
    assign shifted   = {rem, quo[XLEN-1]};
    assign diff      = shifted - {1'b0, den};
    assign fits      = shifted >= {1'b0, den};
    // Divide by zero needs an explicit all-ones quotient; the sign fix-up would corrupt it.
    assign q_res     = div0 ? '1 : (neg_q ? -quo : quo);
    assign r_res     = neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && r_div) state_next = DIV_BUSY;
            DIV_BUSY: if (flush || div_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Operates on magnitudes; signs are reapplied when the result is written out.
    always_ff @(posedge clk) begin
        if (accept && r_div) begin
            quo      <= rs1_neg ? -a : a;
            den      <= rs2_neg ? -io.in_rs2_v : io.in_rs2_v;
            rem      <= '0;
            neg_q    <= rs1_neg ^ rs2_neg;
            neg_r    <= rs1_neg;
            div0     <= (io.in_rs2_v == '0);
            want_rem <= (io.in_op == 5'd25) || (io.in_op == 5'd26);
            div_rd   <= io.in_rd;
            cnt      <= '0;
        end else if (state == DIV_BUSY && cnt != CNT_W'(XLEN)) begin
            rem <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], fits};
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign idle = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            io.out_valid     <= 1'b0;
            io.out_data      <= '0;
            io.out_reg_we    <= 1'b0;
            io.out_rd        <= '0;
            io.out_mem_we    <= 1'b0;
            io.out_mem_re    <= 1'b0;
            io.out_mem_addr  <= '0;
            io.out_jump      <= 1'b0;
            io.out_jump_dest <= '0;
            io.out_illegal   <= 1'b0;
        end else if (flush) begin
            io.out_valid <= 1'b0;
        end else begin
            if (io.out_valid && io.out_ready) io.out_valid <= 1'b0;
            if (accept && !r_div) begin
                io.out_valid     <= 1'b1;
                io.out_data      <= r_data;
                io.out_reg_we    <= r_we;
                io.out_rd        <= io.in_rd;
                io.out_mem_we    <= r_mem_we;
                io.out_mem_re    <= r_mem_re;
                io.out_mem_addr  <= r_addr;
                io.out_jump      <= r_jump;
                io.out_jump_dest <= r_dest;
                io.out_illegal   <= r_ill;
            end
`ifdef EXEC_UNIT_MDU_EN
            else if (div_done) begin
                io.out_valid     <= 1'b1;
                io.out_data      <= want_rem ? r_res : q_res;
                io.out_reg_we    <= (div_rd != '0);
                io.out_rd        <= div_rd;
                io.out_mem_we    <= 1'b0;
                io.out_mem_re    <= 1'b0;
                io.out_mem_addr  <= '0;
                io.out_jump      <= 1'b0;
                io.out_jump_dest <= '0;
                io.out_illegal   <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: vector table for single-cycle ops plus sequences for
// backpressure, flush, reset and (with EXEC_UNIT_MDU_EN) the multi-cycle divider.
module tb_exec_unit;
  localparam int XLEN = 32;
  localparam int RD_W = 6;
  localparam int OW   = 6 + RD_W + 3 * XLEN;

  typedef struct {
    logic [4:0]      op;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            s2;
    logic [OW-1:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic dbg_busy;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];
  logic [OW-1:0] exp_q[$];

  exec_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) io ();
  exec_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .io       (io),
    .dbg_busy (dbg_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] outs();
    return {io.out_valid, io.out_illegal, io.out_jump, io.out_mem_re, io.out_mem_we,
            io.out_reg_we, io.out_rd, io.out_data, io.out_mem_addr, io.out_jump_dest};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [RD_W-1:0] rd, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] imm, input logic s2,
                         input logic ill, input logic jmp, input logic mre, input logic mwe,
                         input logic we, input logic [XLEN-1:0] data,
                         input logic [XLEN-1:0] addr, input logic [XLEN-1:0] dest);
    vec_t v;
    v.op = op; v.rd = rd; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.s2 = s2;
    v.exp = {1'b1, ill, jmp, mre, mwe, we, rd, data, addr, dest};
    vecs.push_back(v);
  endtask

  // driver
  task automatic drive(input logic [4:0] op, input logic [RD_W-1:0] rd, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] imm, input logic s2);
    io.in_valid = 1'b1; io.in_op = op; io.in_rd = rd; io.in_pc = pc;
    io.in_rs1_v = rs1; io.in_rs2_v = rs2; io.in_imm = imm; io.in_src2_imm = s2;
  endtask

`ifdef EXEC_UNIT_MDU_EN
  task automatic div_run(input string nm, input logic [4:0] op, input logic [XLEN-1:0] x,
                         input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp_data);
    int edges;
    int rdy_bad;
    edges = 0;
    rdy_bad = 0;
    @(negedge clk);
    drive(op, 6'd9, '0, x, y, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk({nm, "_busy"}, dbg_busy, 1'b1);
    while (!io.out_valid && edges < 100) begin
      if (io.in_ready) rdy_bad++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, edges, XLEN + 1);
    chk({nm, "_ready_low"}, rdy_bad, 0);
    chk({nm, "_data"}, {io.out_reg_we, io.out_rd, io.out_data}, {1'b1, 6'd9, exp_data});
  endtask
`endif

  initial begin
    io.in_valid = 1'b0; io.in_op = '0; io.in_rd = '0; io.in_pc = '0;
    io.in_rs1_v = '0; io.in_rs2_v = '0; io.in_imm = '0; io.in_src2_imm = 1'b0;
    io.out_ready = 1'b1;

    //        op     rd     pc            rs1           rs2           imm           s2  ill jmp mre mwe we  data          addr          dest
    add_vec(5'd0,  6'd7,  32'h0,        32'd5,        32'd0,        32'hFFFFFFFD, 1, 0, 0, 0, 0, 1, 32'd2,        32'h0,        32'h0);
    add_vec(5'd1,  6'd1,  32'h0,        32'd3,        32'd5,        32'h0,        0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 32'h0,        32'h0);
    add_vec(5'd2,  6'd2,  32'h0,        32'hF0F0,     32'hFF00,     32'h0,        0, 0, 0, 0, 0, 1, 32'hF000,     32'h0,        32'h0);
    add_vec(5'd3,  6'd2,  32'h0,        32'hF0F0,     32'h0F0F,     32'h0,        0, 0, 0, 0, 0, 1, 32'hFFFF,     32'h0,        32'h0);
    add_vec(5'd4,  6'd3,  32'h0,        32'hFF,       32'h0F,       32'h0,        0, 0, 0, 0, 0, 1, 32'hF0,       32'h0,        32'h0);
    add_vec(5'd5,  6'd4,  32'h0,        32'd1,        32'd0,        32'h21,       1, 0, 0, 0, 0, 1, 32'd2,        32'h0,        32'h0);
    add_vec(5'd6,  6'd5,  32'h0,        32'h80000000, 32'd31,       32'h0,        0, 0, 0, 0, 0, 1, 32'd1,        32'h0,        32'h0);
    add_vec(5'd7,  6'd6,  32'h0,        32'h80000000, 32'd4,        32'h0,        0, 0, 0, 0, 0, 1, 32'hF8000000, 32'h0,        32'h0);
    add_vec(5'd8,  6'd8,  32'h0,        32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 0, 0, 0, 1, 32'd1,        32'h0,        32'h0);
    add_vec(5'd9,  6'd9,  32'h0,        32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 0, 0, 0, 1, 32'd0,        32'h0,        32'h0);
    add_vec(5'd10, 6'd10, 32'h0,        32'h0,        32'h0,        32'h12345000, 0, 0, 0, 0, 0, 1, 32'h12345000, 32'h0,        32'h0);
    add_vec(5'd11, 6'd11, 32'h1000,     32'h0,        32'h0,        32'h20,       0, 0, 0, 0, 0, 1, 32'h1020,     32'h0,        32'h0);
    add_vec(5'd12, 6'd0,  32'h100,      32'h0,        32'h0,        32'h20,       0, 0, 1, 0, 0, 0, 32'h104,      32'h0,        32'h120);
    add_vec(5'd13, 6'd1,  32'h200,      32'h301,      32'h0,        32'h10,       0, 0, 1, 0, 0, 1, 32'h204,      32'h0,        32'h310);
    add_vec(5'd14, 6'd5,  32'h40,       32'd4,        32'd4,        32'd8,        0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd15, 6'd5,  32'h40,       32'd9,        32'd9,        32'd8,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd16, 6'd5,  32'h40,       32'hFFFFFFFE, 32'd1,        32'd8,        0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd17, 6'd5,  32'h40,       32'hFFFFFFFE, 32'd1,        32'd8,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd18, 6'd5,  32'h40,       32'd1,        32'hFFFFFFFF, 32'd8,        0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd19, 6'd5,  32'h40,       32'hFFFFFFFF, 32'd1,        32'd8,        0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h48);
    add_vec(5'd20, 6'd3,  32'h0,        32'h1000,     32'h0,        32'hFFFFFFFC, 0, 0, 0, 1, 0, 1, 32'h0,        32'hFFC,      32'h0);
    add_vec(5'd21, 6'd0,  32'h0,        32'h2000,     32'hDEADBEEF, 32'd8,        0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h2008,     32'h0);
    add_vec(5'd27, 6'd3,  32'h40,       32'd1,        32'd1,        32'd8,        0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    add_vec(5'd31, 6'd3,  32'h40,       32'd1,        32'd1,        32'd8,        0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    add_vec(5'd0,  6'd0,  32'h0,        32'd1,        32'd2,        32'h0,        0, 0, 0, 0, 0, 0, 32'd3,        32'h0,        32'h0);
`ifdef EXEC_UNIT_MDU_EN
    add_vec(5'd22, 6'd1,  32'h0,        32'd7,        32'hFFFFFFFD, 32'h0,        0, 0, 0, 0, 0, 1, 32'hFFFFFFEB, 32'h0,        32'h0);
`else
    for (int k = 22; k <= 26; k++)
      add_vec(5'(k), 6'd1, 32'h0,     32'd7,        32'd3,        32'h0,        0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), '0);
    chk("reset_in_ready", io.in_ready, 1'b1);
    chk("reset_idle", dbg_busy, 1'b0);
    rst = 1'b0;

    // vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].rd, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].s2);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      @(negedge clk);
      io.in_valid = 1'b0;
      chk($sformatf("vec%0d_op%0d", i, vecs[i].op), outs(), exp_q.pop_front());
    end

    // flush drops a same-cycle request
    @(negedge clk);
    drive(5'd0, 6'd4, '0, 32'd1, 32'd1, '0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    io.in_valid = 1'b0;
    chk("flush_drops_req", io.out_valid, 1'b0);

    // backpressure holds the result; flush then clears it
    @(negedge clk);
    io.out_ready = 1'b0;
    drive(5'd0, 6'd4, '0, 32'd10, 32'd20, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(5'd4, 6'd2, '0, 32'd1, 32'd2, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d_outs", k), outs(), {1'b1, 5'b00001, 6'd4, 32'd30, 32'h0, 32'h0});
      chk($sformatf("hold%0d_in_ready", k), io.in_ready, 1'b0);
      if (k < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_clears_valid", io.out_valid, 1'b0);
    chk("flush_in_ready", io.in_ready, 1'b1);
    drive(5'd1, 6'd2, '0, 32'd50, 32'd8, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("after_flush_op", {io.out_valid, io.out_data}, {1'b1, 32'd42});
    io.out_ready = 1'b1;

    // reset while a result is pending
    @(negedge clk);
    io.out_ready = 1'b0;
    drive(5'd12, 6'd3, 32'h80, '0, '0, 32'h40, 1'b0);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    io.out_ready = 1'b1;
    chk("rst_pending_outs", outs(), '0);

`ifdef EXEC_UNIT_MDU_EN
    div_run("div_min_neg1", 5'd23, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    div_run("divu_by0",     5'd24, 32'd7,        32'd0,        32'hFFFFFFFF);
    div_run("rem_min_neg1", 5'd25, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    div_run("remu_by0",     5'd26, 32'd7,        32'd0,        32'd7);
    div_run("div_neg7_2",   5'd23, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    div_run("rem_neg7_2",   5'd25, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    div_run("div_neg_by0",  5'd23, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    div_run("rem_neg_by0",  5'd25, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
    div_run("divu_100_7",   5'd24, 32'd100,      32'd7,        32'd14);

    // reset in the middle of a division
    begin
      int stale;
      stale = 0;
      @(negedge clk);
      drive(5'd24, 6'd5, '0, 32'd100, 32'd7, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      io.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_div_valid", io.out_valid, 1'b0);
      chk("rst_div_idle", {dbg_busy, io.in_ready}, 2'b01);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (io.out_valid) stale++;
      end
      chk("rst_div_no_stale", stale, 0);
    end

    // flush aborts a division
    @(negedge clk);
    drive(5'd24, 6'd5, '0, 32'd100, 32'd7, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_idle", {dbg_busy, io.in_ready, io.out_valid}, 3'b010);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
